ssp_rx_ctrl: RTL

- Receive-side sequencer for the SSP.
- Detects SSPCLKIN rising edges in the PCLK domain and frames bytes on SSPFSSIN.
- Deserialises SSPRXD MSB-first, then schedules writes into an external 4x8 receive RAM.
- Manages write/read pointers and occupancy, serves processor reads (PSEL & !PWRITE), and raises SSPRXINTR when the buffer is full.

---
 rtl/ssp_pkg.sv | 15 +
 rtl/ssp_rx_shifter.sv | 52 +++++
 rtl/ssp_rx_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/ssp_pkg.sv
// Shared constants and FSM encoding for the SSP receive path.
package ssp_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;

    // Receive sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/ssp_rx_shifter.sv
// SSPCLKIN rising-edge detect, bit counter and MSB-first shift register.
// The shifter only runs while shift_en_i is high; the bit counter is held at
// zero otherwise so every frame starts counting from bit 0.
module ssp_rx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              pclk_i,
    input  logic              clear_i,
    input  logic              sspclkin_i,
    input  logic              rxd_i,
    input  logic              shift_en_i,
    output logic              rise_o,
    output logic              byte_done_o,
    output logic [DATA_W-1:0] rx_byte_o
);

    localparam int CW = $clog2(DATA_W);

    logic              clk_d_q;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;

    assign rise_o      = sspclkin_i & ~clk_d_q;
    assign byte_done_o = shift_en_i & rise_o & (bit_cnt_q == CW'(DATA_W - 1));
    assign rx_byte_o   = sr_q;

    // Shift in one bit per serial clock rise; counter wraps to 0 after the last bit
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        if (!shift_en_i) begin
            bit_cnt_d = '0;
        end else if (rise_o) begin
            sr_d      = {sr_q[DATA_W-2:0], rxd_i};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    // Edge-detect delay, counter and shift register
    always_ff @(posedge pclk_i) begin
        if (clear_i) begin
            clk_d_q   <= 1'b0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
        end else begin
            clk_d_q   <= sspclkin_i;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
        end
    end

endmodule

// File: rtl/ssp_rx_ctrl.sv
// SSP receive sequencer: frames serial bytes, writes them into an external
// DEPTH-entry RAM and serves processor reads from it.
// Handshake: a push happens in the single PUSH cycle when there is room (or a
// pop frees room in the same cycle); a pop happens in any cycle with
// PSEL & !PWRITE while the buffer is non-empty, and PRDATA updates on that edge.
module ssp_rx_ctrl
    import ssp_pkg::*;
#(
    parameter int DATA_W = ssp_pkg::DATA_W,
    parameter int DEPTH  = ssp_pkg::DEPTH,
    parameter int AW     = ssp_pkg::AW
) (
    input  logic              PCLK,
    input  logic              CLEAR,
    input  logic              PSEL,
    input  logic              PWRITE,
    input  logic              SSPCLKIN,
    input  logic              SSPFSSIN,
    input  logic              SSPRXD,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic [AW-1:0]     ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [AW-1:0]     ram_raddr,
    output logic [DATA_W-1:0] PRDATA,
    output logic              SSPRXINTR,
    output logic              rx_overrun
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    rx_state_e         state_q, state_d;
    logic              armed_q, armed_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] prdata_q;
    logic              intr_q, overrun_q;

    logic              rise, byte_done, shift_en;
    logic [DATA_W-1:0] rx_byte;
    logic              pop, accept, push;

    ssp_rx_shifter #(.DATA_W(DATA_W)) u_shifter (
        .pclk_i      (PCLK),
        .clear_i     (CLEAR),
        .sspclkin_i  (SSPCLKIN),
        .rxd_i       (SSPRXD),
        .shift_en_i  (shift_en),
        .rise_o      (rise),
        .byte_done_o (byte_done),
        .rx_byte_o   (rx_byte)
    );

    assign shift_en = (state_q == SHIFT);
    assign pop      = PSEL & ~PWRITE & (count_q != '0);
    assign accept   = (count_q != FULL) | pop;
    assign push     = (state_q == PUSH) & accept;

    // Next state: frame start in IDLE, collect bits in SHIFT, one-cycle PUSH
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        case (state_q)
            IDLE:    if (rise && SSPFSSIN) state_d = SHIFT;
            SHIFT:   if (byte_done) begin
                         state_d = PUSH;
                         armed_d = SSPFSSIN;
                     end
            PUSH:    state_d = armed_q ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State, pointers, occupancy, read data and status flags
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            prdata_q  <= '0;
            intr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            count_q <= count_d;
            intr_q  <= (count_d == FULL);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                prdata_q <= ram_rdata;
            end
            if ((state_q == PUSH) && !accept) overrun_q <= 1'b1;
        end
    end

    assign ram_we     = push;
    assign ram_waddr  = wr_ptr_q;
    assign ram_wdata  = rx_byte;
    assign ram_raddr  = rd_ptr_q;
    assign PRDATA     = prdata_q;
    assign SSPRXINTR  = intr_q;
    assign rx_overrun = overrun_q;

endmodule
